// File: rtl/input_conditioner_if.sv
// ----------------------------------------------------------------------------
// input_conditioner_if
//   Groups the raw board inputs and the conditioned outputs of the DE10-Lite
//   input front end.
//   master : drives raw SW/KEY, receives the conditioned levels and pulses
//   slave  : the conditioner itself
//   Signals:
//     SW          [N_SW]   raw slide switches, 1 = up
//     KEY         [N_KEY]  raw push-buttons, active-low
//     SW_DB       [N_SW]   debounced switch levels
//     KEY_DB      [N_KEY]  debounced key levels, 1 = pressed
//     KEY_PRESS   [N_KEY]  one-cycle pulse on press (and on auto-repeat)
//     KEY_RELEASE [N_KEY]  one-cycle pulse on release
// ----------------------------------------------------------------------------
interface input_conditioner_if #(
    parameter int N_SW  = 10,
    parameter int N_KEY = 2
);
    logic [N_SW-1:0]  SW;
    logic [N_KEY-1:0] KEY;
    logic [N_SW-1:0]  SW_DB;
    logic [N_KEY-1:0] KEY_DB;
    logic [N_KEY-1:0] KEY_PRESS;
    logic [N_KEY-1:0] KEY_RELEASE;

    modport master (
        output SW, KEY,
        input  SW_DB, KEY_DB, KEY_PRESS, KEY_RELEASE
    );

    modport slave (
        input  SW, KEY,
        output SW_DB, KEY_DB, KEY_PRESS, KEY_RELEASE
    );
endinterface

// File: rtl/input_conditioner.sv
// ----------------------------------------------------------------------------
// input_conditioner
//   Synchronises and debounces the DE10-Lite slide switches and push-buttons,
//   turns the active-low KEY pins into active-high "pressed" levels and emits
//   one-cycle press/release pulses for the downstream display stage.
//
//   Ports:
//     MAX10_CLK1_50  in   50 MHz system clock
//     RESET_N        in   asynchronous active-low reset
//     io             slave modport of input_conditioner_if (SW, KEY in;
//                    SW_DB, KEY_DB, KEY_PRESS, KEY_RELEASE out)
//
//   Optional feature: define KEY_REPEAT_EN to add per-key auto-repeat
//   (first repeat REPEAT_DELAY cycles after the press, then every
//   REPEAT_PERIOD cycles). Without it the REPEAT_* parameters are unused.
// ----------------------------------------------------------------------------
module input_conditioner #(
    parameter int N_SW            = 10,
    parameter int N_KEY           = 2,
    parameter int SYNC_STAGES     = 2,        // 2..4
    parameter int DEBOUNCE_CYCLES = 1000000,  // >= 2
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic              MAX10_CLK1_50,
    input  logic              RESET_N,
    input_conditioner_if.slave io
);
    // Switches occupy the low bits, keys the high bits of one conditioned
    // vector, so every bit goes through the identical sync/debounce path.
    localparam int NB = N_SW + N_KEY;
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    // Key bits: sync flops idle high and are inverted after synchronising.
    localparam logic [NB-1:0] KEY_MASK = {{N_KEY{1'b1}}, {N_SW{1'b0}}};

    logic [NB-1:0]                  raw_in;
    logic [NB-1:0][SYNC_STAGES-1:0] sync_q;
    logic [NB-1:0][CW-1:0]          cnt_q;
    logic [NB-1:0]                  synced;
    logic [NB-1:0]                  db_q;
    logic [NB-1:0]                  db_d;
    logic [N_KEY-1:0]               key_rise;
    logic [N_KEY-1:0]               key_fall;
    logic [N_KEY-1:0]               press_q;
    logic [N_KEY-1:0]               release_q;

    assign raw_in = {io.KEY, io.SW};

    // ------------------------------------------------------------------
    // Debounce: the output only moves on the edge where the count of
    // consecutive disagreeing samples completes; any agreeing sample
    // restarts the count.
    // ------------------------------------------------------------------
    always_comb begin
        synced = '0;
        db_d   = db_q;
        for (int b = 0; b < NB; b++) begin
            synced[b] = sync_q[b][SYNC_STAGES-1] ^ KEY_MASK[b];
            if ((synced[b] != db_q[b]) && (cnt_q[b] == CNT_LAST))
                db_d[b] = synced[b];
        end
    end

    always_ff @(posedge MAX10_CLK1_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int b = 0; b < NB; b++) begin
                sync_q[b] <= {SYNC_STAGES{KEY_MASK[b]}};
                cnt_q[b]  <= '0;
            end
            db_q <= '0;
        end else begin
            for (int b = 0; b < NB; b++) begin
                sync_q[b] <= {sync_q[b][SYNC_STAGES-2:0], raw_in[b]};
                if ((synced[b] == db_q[b]) || (cnt_q[b] == CNT_LAST))
                    cnt_q[b] <= '0;
                else
                    cnt_q[b] <= cnt_q[b] + CW'(1);
            end
            db_q <= db_d;
        end
    end

    // Edges are taken from the next-state value so the pulse flops rise on
    // the same clock edge as KEY_DB.
    always_comb begin
        key_rise = '0;
        key_fall = '0;
        for (int k = 0; k < N_KEY; k++) begin
            key_rise[k] =  db_d[N_SW+k] & ~db_q[N_SW+k];
            key_fall[k] = ~db_d[N_SW+k] &  db_q[N_SW+k];
        end
    end

`ifdef KEY_REPEAT_EN
    // ------------------------------------------------------------------
    // Auto-repeat: WAIT counts the initial hold delay, RPT the period
    // between repeats. A release in any state wins over a repeat pulse.
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {RS_IDLE, RS_WAIT, RS_RPT} rpt_state_e;

    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW      = (RPT_MAX > 2) ? $clog2(RPT_MAX) : 1;
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

    rpt_state_e      rpt_state [N_KEY];
    logic [RW-1:0]   rpt_cnt   [N_KEY];

    always_ff @(posedge MAX10_CLK1_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            press_q   <= '0;
            release_q <= '0;
            for (int k = 0; k < N_KEY; k++) begin
                rpt_state[k] <= RS_IDLE;
                rpt_cnt[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < N_KEY; k++) begin
                press_q[k]   <= key_rise[k];
                release_q[k] <= key_fall[k];
                if (key_fall[k]) begin
                    rpt_state[k] <= RS_IDLE;
                    rpt_cnt[k]   <= '0;
                end else begin
                    case (rpt_state[k])
                        RS_IDLE: begin
                            if (key_rise[k]) begin
                                rpt_state[k] <= RS_WAIT;
                                rpt_cnt[k]   <= '0;
                            end
                        end
                        RS_WAIT: begin
                            if (rpt_cnt[k] == DELAY_LAST) begin
                                press_q[k]   <= 1'b1;
                                rpt_cnt[k]   <= '0;
                                rpt_state[k] <= RS_RPT;
                            end else begin
                                rpt_cnt[k] <= rpt_cnt[k] + RW'(1);
                            end
                        end
                        RS_RPT: begin
                            if (rpt_cnt[k] == PERIOD_LAST) begin
                                press_q[k] <= 1'b1;
                                rpt_cnt[k] <= '0;
                            end else begin
                                rpt_cnt[k] <= rpt_cnt[k] + RW'(1);
                            end
                        end
                        default: begin
                            rpt_state[k] <= RS_IDLE;
                            rpt_cnt[k]   <= '0;
                        end
                    endcase
                end
            end
        end
    end
`else
    always_ff @(posedge MAX10_CLK1_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            press_q   <= '0;
            release_q <= '0;
        end else begin
            press_q   <= key_rise;
            release_q <= key_fall;
        end
    end
`endif

    assign io.SW_DB       = db_q[N_SW-1:0];
    assign io.KEY_DB      = db_q[NB-1:N_SW];
    assign io.KEY_PRESS   = press_q;
    assign io.KEY_RELEASE = release_q;

endmodule

// File: tb/tb_input_conditioner.sv
module tb_input_conditioner;
    localparam int N_SW  = 10;
    localparam int N_KEY = 2;
    localparam int SYNC  = 2;
    localparam int DC    = 4;
    localparam int RD    = 10;
    localparam int RP    = 3;
    localparam int NB    = N_SW + N_KEY;
    localparam int OW    = N_SW + 3*N_KEY;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    input_conditioner_if #(.N_SW(N_SW), .N_KEY(N_KEY)) io ();

    input_conditioner #(
        .N_SW(N_SW), .N_KEY(N_KEY), .SYNC_STAGES(SYNC),
        .DEBOUNCE_CYCLES(DC), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .MAX10_CLK1_50(clk),
        .RESET_N(rst_n),
        .io(io)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: an input is accepted once the last DC synchronised
    // samples all disagree with the current output; synchronised samples
    // are the raw inputs delayed by SYNC edges. Repeats follow the hold age.
    // ------------------------------------------------------------------
    logic [NB-1:0]    raw_q [$];
    logic [NB-1:0]    win   [$];
    logic [NB-1:0]    m_db, m_nxt, m_seen;
    logic [N_KEY-1:0] m_press, m_rel;
    logic             m_flip, m_rise, m_fall;
    int               m_age [N_KEY];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raw_q.delete();
            repeat (SYNC) raw_q.push_back('0);
            win.delete();
            repeat (DC) win.push_back('0);
            m_db = '0; m_press = '0; m_rel = '0;
            for (int k = 0; k < N_KEY; k++) m_age[k] = 0;
        end else begin
            m_seen = raw_q.pop_front();
            raw_q.push_back({~io.KEY, io.SW});
            win.push_back(m_seen);
            void'(win.pop_front());
            m_nxt = m_db;
            for (int b = 0; b < NB; b++) begin
                m_flip = 1'b1;
                foreach (win[j]) if (win[j][b] == m_db[b]) m_flip = 1'b0;
                if (m_flip) m_nxt[b] = ~m_db[b];
            end
            for (int k = 0; k < N_KEY; k++) begin
                m_rise = m_nxt[N_SW+k] & ~m_db[N_SW+k];
                m_fall = ~m_nxt[N_SW+k] & m_db[N_SW+k];
                m_press[k] = m_rise;
                m_rel[k]   = m_fall;
                if (m_rise) m_age[k] = 0;
                else if (m_nxt[N_SW+k]) m_age[k] = m_age[k] + 1;
`ifdef KEY_REPEAT_EN
                if (m_nxt[N_SW+k] && !m_rise && m_age[k] >= RD && ((m_age[k] - RD) % RP) == 0)
                    m_press[k] = 1'b1;
`endif
            end
            m_db = m_nxt;
        end
    end

    logic [OW-1:0] obs, exp_all;
    assign obs     = {io.SW_DB, io.KEY_DB, io.KEY_PRESS, io.KEY_RELEASE};
    assign exp_all = {m_db[N_SW-1:0], m_db[NB-1:N_SW], m_press, m_rel};

    // ------------------------------------------------------------------
    task automatic test_reset;
        rst_n = 1'b0;
        io.SW = 10'h3FF;
        io.KEY = 2'b00;
        repeat (3) @(negedge clk);
        checks++;
        if (obs !== '0) begin errors++; $display("FAIL reset_outputs got=%h exp=0", obs); end
        rst_n = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_all) begin errors++; $display("FAIL model_reset t=%0t got=%h exp=%h", $time, obs, exp_all); end
            if (e == 5) begin
                checks++;
                if (io.SW_DB !== 10'h000 || io.KEY_DB !== 2'b00) begin
                    errors++; $display("FAIL reset_early sw=%h key=%b exp 000/00", io.SW_DB, io.KEY_DB);
                end
            end
            if (e == 6) begin
                checks++;
                if ({io.SW_DB, io.KEY_DB, io.KEY_PRESS} !== {10'h3FF, 2'b11, 2'b11}) begin
                    errors++; $display("FAIL reset_accept sw=%h db=%b press=%b exp 3ff/11/11", io.SW_DB, io.KEY_DB, io.KEY_PRESS);
                end
            end
            if (e == 7) begin
                checks++;
                if (io.KEY_PRESS !== 2'b00) begin errors++; $display("FAIL reset_press_width got=%b exp=00", io.KEY_PRESS); end
            end
        end
    endtask

    task automatic test_sw_latency;
        io.SW = 10'b11_1111_0000;
        for (int e = 1; e <= 7; e++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_all) begin errors++; $display("FAIL model_sw t=%0t got=%h exp=%h", $time, obs, exp_all); end
            if (e == 5) begin
                checks++;
                if (io.SW_DB[7:0] !== 8'hFF) begin errors++; $display("FAIL sw_latency_5 got=%h exp=ff", io.SW_DB[7:0]); end
            end
            if (e == 6) begin
                checks++;
                if (io.SW_DB[7:0] !== 8'hF0) begin errors++; $display("FAIL sw_latency_6 got=%h exp=f0", io.SW_DB[7:0]); end
            end
        end
    endtask

    task automatic test_key_bounce;
        logic [4:0] bseq;
        int presses;
        int releases;
        bseq = 5'b01010;
        presses = 0;
        releases = 0;
        io.KEY[0] = 1'b1;
        repeat (8) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_all) begin errors++; $display("FAIL model_krel t=%0t got=%h exp=%h", $time, obs, exp_all); end
        end
        for (int i = 0; i < 5; i++) begin
            io.KEY[0] = bseq[i];
            if (i < 4) begin
                @(negedge clk);
                checks++;
                if (obs !== exp_all) begin errors++; $display("FAIL model_bounce t=%0t got=%h exp=%h", $time, obs, exp_all); end
                presses += int'(io.KEY_PRESS[0]);
                releases += int'(io.KEY_RELEASE[0]);
            end
        end
        for (int e = 1; e <= 8; e++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_all) begin errors++; $display("FAIL model_bounce t=%0t got=%h exp=%h", $time, obs, exp_all); end
            presses += int'(io.KEY_PRESS[0]);
            releases += int'(io.KEY_RELEASE[0]);
            if (e == 5) begin
                checks++;
                if (io.KEY_DB[0] !== 1'b0) begin errors++; $display("FAIL bounce_early got=%b exp=0", io.KEY_DB[0]); end
            end
            if (e == 6) begin
                checks++;
                if (io.KEY_DB[0] !== 1'b1) begin errors++; $display("FAIL bounce_accept got=%b exp=1", io.KEY_DB[0]); end
            end
        end
        checks++;
        if (presses != 1 || releases != 0) begin
            errors++; $display("FAIL bounce_pulses press=%0d rel=%0d exp 1/0", presses, releases);
        end
    endtask

    task automatic test_both_release;
        io.KEY = 2'b11;
        for (int e = 1; e <= 7; e++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_all) begin errors++; $display("FAIL model_both t=%0t got=%h exp=%h", $time, obs, exp_all); end
            if (e == 5) begin
                checks++;
                if (io.KEY_RELEASE !== 2'b00 || io.KEY_DB !== 2'b11) begin
                    errors++; $display("FAIL both_early rel=%b db=%b exp 00/11", io.KEY_RELEASE, io.KEY_DB);
                end
            end
            if (e == 6) begin
                checks++;
                if (io.KEY_RELEASE !== 2'b11 || io.KEY_DB !== 2'b00 || io.KEY_PRESS !== 2'b00) begin
                    errors++; $display("FAIL both_release rel=%b db=%b press=%b exp 11/00/00", io.KEY_RELEASE, io.KEY_DB, io.KEY_PRESS);
                end
            end
            if (e == 7) begin
                checks++;
                if (io.KEY_RELEASE !== 2'b00) begin errors++; $display("FAIL both_width got=%b exp=00", io.KEY_RELEASE); end
            end
        end
    endtask

    task automatic test_reset_midcount;
        int pulses;
        pulses = 0;
        io.SW[3] = 1'b1;
        repeat (4) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_all) begin errors++; $display("FAIL model_mid t=%0t got=%h exp=%h", $time, obs, exp_all); end
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== '0) begin errors++; $display("FAIL async_reset got=%h exp=0", obs); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_all) begin errors++; $display("FAIL model_rearm t=%0t got=%h exp=%h", $time, obs, exp_all); end
            pulses += $countones({io.KEY_PRESS, io.KEY_RELEASE});
            if (e == 5) begin
                checks++;
                if (io.SW_DB !== 10'h000) begin errors++; $display("FAIL rearm_early got=%h exp=000", io.SW_DB); end
            end
            if (e == 6) begin
                checks++;
                if (io.SW_DB !== 10'b11_1111_1000) begin errors++; $display("FAIL rearm_accept got=%h exp=3f8", io.SW_DB); end
            end
        end
        checks++;
        if (pulses != 0) begin errors++; $display("FAIL stale_pulse count=%0d exp=0", pulses); end
    endtask

    task automatic test_repeat;
        logic [29:0] pm, exp_pm;
        bit seen;
        bit fell;
        int rel;
        int post_press;
        seen = 0;
        io.KEY = 2'b01;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_all) begin errors++; $display("FAIL model_rpt t=%0t got=%h exp=%h", $time, obs, exp_all); end
            if (io.KEY_DB[1] === 1'b1) seen = 1;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL rpt_press_timeout got=%b exp=1", io.KEY_DB[1]); end
        pm = '0;
        for (int off = 0; off < 30; off++) begin
            if (off > 0) begin
                @(negedge clk);
                checks++;
                if (obs !== exp_all) begin errors++; $display("FAIL model_rpt t=%0t got=%h exp=%h", $time, obs, exp_all); end
            end
            pm[off] = io.KEY_PRESS[1];
        end
        exp_pm = 30'd1;
`ifdef KEY_REPEAT_EN
        for (int a = RD; a < 30; a += RP) exp_pm[a] = 1'b1;
`endif
        checks++;
        if (pm !== exp_pm) begin errors++; $display("FAIL rpt_pattern got=%b exp=%b", pm, exp_pm); end
        io.KEY = 2'b11;
        fell = 0; rel = 0; post_press = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_all) begin errors++; $display("FAIL model_rpt_rel t=%0t got=%h exp=%h", $time, obs, exp_all); end
            rel += int'(io.KEY_RELEASE[1]);
            if (io.KEY_DB[1] === 1'b0) fell = 1;
            if (fell) post_press += int'(io.KEY_PRESS[1]);
        end
        checks++;
        if (!fell || rel != 1 || post_press != 0) begin
            errors++; $display("FAIL rpt_release fell=%0d rel=%0d press=%0d exp 1/1/0", fell, rel, post_press);
        end
    endtask

    task automatic test_random;
        int hold;
        hold = 0;
        for (int c = 0; c < 400; c++) begin
            if (hold == 0) begin
                io.SW  = io.SW ^ N_SW'($urandom & $urandom);
                io.KEY = N_KEY'($urandom);
                hold   = int'($urandom_range(1, 9));
            end
            hold--;
            if (c == 200) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
            @(negedge clk);
            checks++;
            if (obs !== exp_all) begin errors++; $display("FAIL model_random c=%0d got=%h exp=%h", c, obs, exp_all); end
        end
    endtask

    initial begin
        io.SW  = '0;
        io.KEY = '1;
        test_reset();
        test_sw_latency();
        test_key_bounce();
        test_both_release();
        test_reset_midcount();
        test_repeat();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
